// File: rtl/vend_credit_fsm.sv
// rtl/vend_credit_fsm.sv - coin credit vending FSM with registered Moore outputs
// Build option: define VEND_CHANGE_EN to pay out change on vend instead of carrying credit over.
module vend_credit_fsm #(
   parameter int CREDIT_W   = 4,
   parameter int PRICE      = 3,
   parameter int MAX_CREDIT = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin5,
   input  logic                coin10,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state_o,
   output logic                dispense,
   output logic                refund,
   output logic [CREDIT_W-1:0] change,
   output logic                reject
);
   localparam int SW = CREDIT_W + 2;
   localparam logic [SW-1:0]       PRICE_W = SW'(PRICE);
   localparam logic [SW-1:0]       MAX_W   = SW'(MAX_CREDIT);
   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      VEND   = 2'd2,
      REFUND = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic                dispense_q, refund_q, reject_q, reject_d;
   logic                coin_any;
   logic [SW-1:0]       coin_v, sum;

   assign coin_any = coin5 | coin10;
   assign coin_v   = SW'(coin5) + (SW'(coin10) << 1);
   // Two guard bits keep credit+coin from wrapping before the ceiling test.
   assign sum      = SW'(credit_q) + coin_v;

`ifndef VEND_CHANGE_EN
   logic [SW-1:0] rem;
   assign rem = SW'(credit_q) - PRICE_W;
`endif

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      reject_d = 1'b0;
      case (state_q)
         IDLE, ACCUM: begin
            if (cancel) begin
               state_d  = REFUND;
               reject_d = coin_any;
            end else if (coin_any) begin
               if (sum > MAX_W) begin
                  reject_d = 1'b1;
               end else begin
                  credit_d = sum[CREDIT_W-1:0];
                  state_d  = (sum >= PRICE_W) ? VEND : ACCUM;
               end
            end
         end
         VEND: begin
            reject_d = coin_any;
`ifdef VEND_CHANGE_EN
            state_d  = IDLE;
            credit_d = '0;
`else
            credit_d = rem[CREDIT_W-1:0];
            if (rem >= PRICE_W)
               state_d = VEND;
            else if (rem != '0)
               state_d = ACCUM;
            else
               state_d = IDLE;
`endif
         end
         REFUND: begin
            reject_d = coin_any;
            state_d  = IDLE;
            credit_d = '0;
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase

      change_d = '0;
      if (state_d == REFUND)
         change_d = credit_d;
`ifdef VEND_CHANGE_EN
      else if (state_d == VEND)
         change_d = credit_d - PRICE_C;
`endif
   end

   // Pulse outputs are derived from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         credit_q   <= '0;
         dispense_q <= 1'b0;
         refund_q   <= 1'b0;
         change_q   <= '0;
         reject_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         dispense_q <= (state_d == VEND);
         refund_q   <= (state_d == REFUND);
         change_q   <= change_d;
         reject_q   <= reject_d;
      end
   end

   assign credit   = credit_q;
   assign state_o  = state_q;
   assign dispense = dispense_q;
   assign refund   = refund_q;
   assign change   = change_q;
   assign reject   = reject_q;
endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb/tb_vend_credit_fsm.sv - scoreboard bench for vend_credit_fsm (default and PRICE=6 instances)
`timescale 1ns/1ps
module tb_vend_credit_fsm;
   localparam bit MAC =
`ifdef VEND_CHANGE_EN
      1'b1;
`else
      1'b0;
`endif
   localparam int IDLE = 0, ACCUM = 1, VEND = 2, REFUND = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic coin5 = 1'b0, coin10 = 1'b0, cancel = 1'b0;
   logic [3:0] credit0, change0, credit1, change1;
   logic [1:0] st0, st1;
   logic disp0, ref0, rej0, disp1, ref1, rej1;

   vend_credit_fsm dut0 (
      .clk(clk), .reset(reset), .coin5(coin5), .coin10(coin10), .cancel(cancel),
      .credit(credit0), .state_o(st0), .dispense(disp0), .refund(ref0),
      .change(change0), .reject(rej0)
   );

   vend_credit_fsm #(.CREDIT_W(4), .PRICE(6), .MAX_CREDIT(6)) dut1 (
      .clk(clk), .reset(reset), .coin5(coin5), .coin10(coin10), .cancel(cancel),
      .credit(credit1), .state_o(st1), .dispense(disp1), .refund(ref1),
      .change(change1), .reject(rej1)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         cyc;
      int         dut;
      logic [12:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   exp_t        m_e;
   logic [12:0] m_act;
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
         m_e   = sb_q.pop_front();
         m_act = (m_e.dut == 0) ? {credit0, st0, disp0, ref0, change0, rej0}
                                : {credit1, st1, disp1, ref1, change1, rej1};
         checks++;
         if (m_act !== m_e.exp) begin
            errors++;
            $display("FAIL %s dut%0d: actual credit=%0d state=%0d disp=%b ref=%b change=%0d rej=%b, required credit=%0d state=%0d disp=%b ref=%b change=%0d rej=%b",
                     m_e.name, m_e.dut, m_act[12:9], m_act[8:7], m_act[6], m_act[5], m_act[4:1], m_act[0],
                     m_e.exp[12:9], m_e.exp[8:7], m_e.exp[6], m_e.exp[5], m_e.exp[4:1], m_e.exp[0]);
         end
      end
   end

   task automatic push(input string nm, input int d, input int tag, input int cr, input int st,
                       input bit dp, input bit rf, input int ch, input bit rj);
      exp_t e;
      e.name = nm;
      e.cyc  = tag;
      e.dut  = d;
      e.exp  = {4'(cr), 2'(st), dp, rf, 4'(ch), rj};
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs; the expectation applies after the edge that samples them.
   task automatic step(input string nm, input int d, input bit c5, input bit c10, input bit cn,
                       input bit chk, input int cr, input int st, input bit dp, input bit rf,
                       input int ch, input bit rj);
      @(posedge clk);
      #1;
      coin5 = c5; coin10 = c10; cancel = cn;
      if (chk) push(nm, d, cyc + 1, cr, st, dp, rf, ch, rj);
   endtask

   task automatic pulse_reset(input string nm, input bit settle);
      if (settle) begin
         @(posedge clk);
         #1 coin5 = 0; coin10 = 0; cancel = 0;
      end
      @(posedge clk);
      #1 coin5 = 0; coin10 = 0; cancel = 0;
      #1 reset = 1'b1;
      push(nm, 0, cyc, 0, IDLE, 0, 0, 0, 0);
      push(nm, 1, cyc, 0, IDLE, 0, 0, 0, 0);
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      pulse_reset("reset_state", 1'b0);

      step("c5_1",        0, 1, 0, 0, 1, 1, ACCUM, 0, 0, 0, 0);
      step("c5_2",        0, 1, 0, 0, 1, 2, ACCUM, 0, 0, 0, 0);
      step("c5_3_vend",   0, 1, 0, 0, 1, 3, VEND,  1, 0, 0, 0);
      step("after_vend",  0, 0, 0, 0, 1, 0, IDLE,  0, 0, 0, 0);

      step("c10_2",       0, 0, 1, 0, 1, 2, ACCUM, 0, 0, 0, 0);
      step("c10_4_vend",  0, 0, 1, 0, 1, 4, VEND,  1, 0, MAC ? 1 : 0, 0);
      step("vend_rem",    0, 0, 0, 0, 1, MAC ? 0 : 1, MAC ? IDLE : ACCUM, 0, 0, 0, 0);
      step("cancel_rem",  0, 0, 0, 1, 1, MAC ? 0 : 1, REFUND, 0, 1, MAC ? 0 : 1, 0);
      step("after_ref",   0, 0, 0, 0, 1, 0, IDLE,  0, 0, 0, 0);

      step("c10_2b",      0, 0, 1, 0, 1, 2, ACCUM, 0, 0, 0, 0);
      step("cancel_coin", 0, 0, 1, 1, 1, 2, REFUND, 0, 1, 2, 1);
      step("ref_idle",    0, 0, 0, 0, 1, 0, IDLE,  0, 0, 0, 0);

      step("both_coins",  0, 1, 1, 0, 1, 3, VEND,  1, 0, 0, 0);
      step("coin_in_vend",0, 1, 0, 0, 1, 0, IDLE,  0, 0, 0, 1);
      step("rej_clear",   0, 0, 0, 0, 1, 0, IDLE,  0, 0, 0, 0);

      step("cancel_idle", 0, 0, 0, 1, 1, 0, REFUND, 0, 1, 0, 0);
      step("coin_in_ref", 0, 0, 1, 0, 1, 0, IDLE,  0, 0, 0, 1);
      step("cr5_vend",    0, 0, 1, 0, 1, 2, ACCUM, 0, 0, 0, 0);
      step("cr5_vend",    0, 1, 1, 0, 1, 5, VEND,  1, 0, MAC ? 2 : 0, 0);
      step("cancel_in_vend", 0, 0, 0, 1, 1, MAC ? 0 : 2, MAC ? IDLE : ACCUM, 0, 0, 0, 0);
      step("after_civ",   0, 0, 0, 0, 1, MAC ? 0 : 2, MAC ? IDLE : ACCUM, 0, 0, 0, 0);

      pulse_reset("reset_mid_credit", 1'b1);
      step("hold_post_rst", 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 0, 0);
      step("c5_post_rst", 0, 1, 0, 0, 1, 1, ACCUM, 0, 0, 0, 0);
      step("c10_3_vend",  0, 0, 1, 0, 0, 0, IDLE, 0, 0, 0, 0);
      pulse_reset("reset_in_vend", 1'b0);
      step("no_pulse_after_rst", 0, 0, 0, 0, 1, 0, IDLE, 0, 0, 0, 0);

      pulse_reset("reset_p6", 1'b1);
      step("p6_c10_2",    1, 0, 1, 0, 1, 2, ACCUM, 0, 0, 0, 0);
      step("p6_c10_4",    1, 0, 1, 0, 1, 4, ACCUM, 0, 0, 0, 0);
      step("p6_c5_5",     1, 1, 0, 0, 1, 5, ACCUM, 0, 0, 0, 0);
      step("p6_overflow", 1, 0, 1, 0, 1, 5, ACCUM, 0, 0, 0, 1);
      step("p6_c5_6_vend",1, 1, 0, 0, 1, 6, VEND,  1, 0, 0, 0);
      step("p6_after",    1, 0, 0, 0, 1, 0, IDLE,  0, 0, 0, 0);

      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vend_credit_fsm.md
VEND_CREDIT_FSM -- requirements
Module: vend_credit_fsm

Interface
REQ-001 Parameter CREDIT_W, default 4: width of every credit-valued port, in half-unit steps.
REQ-002 Parameter PRICE, default 3: vend price in half-units; legal range 1..MAX_CREDIT.
REQ-003 Parameter MAX_CREDIT, default 6: credit ceiling in half-units; legal range PRICE..2^CREDIT_W-1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 coin5  input  1  one 0.5-unit coin this cycle (+1 half-unit).
REQ-007 coin10  input  1  one 1.0-unit coin this cycle (+2 half-units).
REQ-008 cancel  input  1  request refund of all held credit.
REQ-009 credit  output  CREDIT_W  registered credit currently held.
REQ-010 state_o  output  2  current state encoding: IDLE=0, ACCUM=1, VEND=2, REFUND=3.
REQ-011 dispense  output  1  one-cycle vend pulse.
REQ-012 refund  output  1  one-cycle refund pulse.
REQ-013 change  output  CREDIT_W  amount returned; valid only while dispense or refund is 1, else 0.
REQ-014 reject  output  1  one-cycle pulse: a coin sampled in the previous cycle was not accepted.

Function
REQ-015 All outputs SHALL be registered (Moore): each is a function of the state and registers only, never of same-cycle inputs.
REQ-016 Coin value per cycle SHALL be v = coin5 + 2*coin10; both high gives v=3.
REQ-017 IDLE/ACCUM, cancel=1: next state REFUND, credit held; any coin that cycle is discarded and flagged by reject=1 in the next cycle.
REQ-018 IDLE/ACCUM, cancel=0, v>0, credit+v <= MAX_CREDIT: credit <= credit+v; next state VEND if the sum >= PRICE, else ACCUM.
REQ-019 IDLE/ACCUM, cancel=0, credit+v > MAX_CREDIT: the whole cycle's coins are rejected, credit unchanged, reject=1 next cycle.
REQ-020 IDLE/ACCUM, no coin, no cancel: state and credit hold.
REQ-021 VEND (exactly one cycle): dispense=1; handling of the remaining credit is set by the configuration macro.
REQ-022 REFUND (exactly one cycle): refund=1, change=credit; next cycle state IDLE, credit 0.
REQ-023 Coins sampled while in VEND or REFUND SHALL be rejected (reject=1 next cycle); cancel is ignored in those states.
REQ-024 Latency: a coin reaching PRICE at edge N SHALL give dispense=1 in the cycle after edge N.
REQ-025 Credit arithmetic SHALL use CREDIT_W+2 bits internally; no wrap-around is permitted.
REQ-026 An illegal state encoding SHALL go to IDLE with credit 0.

Reset
REQ-027 When reset=1 (asynchronous, regardless of clk), the block SHALL force state IDLE, credit=0, dispense=0, refund=0, change=0, reject=0.
REQ-028 Reset asserted during VEND or REFUND SHALL abort the pulse immediately; no pulse follows reset release.
REQ-029 The first rising clk edge after reset deasserts SHALL sample inputs normally.

Configuration
REQ-030 Macro VEND_CHANGE_EN defined: in VEND, change=credit-PRICE; next state IDLE, credit 0.
REQ-031 Macro VEND_CHANGE_EN undefined: change SHALL stay 0; credit <= credit-PRICE after VEND; next state VEND if the remainder >= PRICE, ACCUM if it is nonzero, else IDLE.

Verification
REQ-032 Defaults; coin5 for 3 consecutive cycles -> credit 1,2,3; dispense=1 in the cycle after the third coin, change=0; then IDLE with credit 0.
REQ-033 Defaults with VEND_CHANGE_EN; credit 2, then coin10 -> credit 4, dispense=1, change=1; next cycle credit 0. Without the macro -> change=0, then ACCUM with credit 1.
REQ-034 Defaults; credit 2, then cancel=1 with coin10=1 the same cycle -> REFUND with change=2, reject=1; next cycle IDLE, credit 0.
REQ-035 PRICE=6, MAX_CREDIT=6; credit 5, then coin10 -> reject=1, credit stays 5; then coin5 -> credit 6 and dispense=1.
REQ-036 Defaults; credit 2, then reset pulsed asynchronously mid-cycle -> all outputs 0 immediately; coin5 after release -> credit 1, state ACCUM.
REQ-037 Defaults; coin5=1 and coin10=1 together from IDLE -> credit 3 and VEND in the next cycle.
